// File: rtl/gmii_frame_tx.sv
// GMII transmit framer: preamble, SFD, payload, optional zero pad, CRC-32 FCS, IFG.
// Define GMII_TX_PAD_EN to zero-pad short frames up to MIN_PAYLOAD bytes before the FCS.
module gmii_frame_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int MIN_PAYLOAD  = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frames_sent
);

  // state    | meaning
  // IDLE     | waiting for s_valid to start a frame
  // PREAMBLE | driving 0x55 bytes
  // SFD      | driving 0xD5, s_ready already high
  // DATA     | driving an accepted payload byte
  // PAD      | driving a 0x00 pad byte
  // FCS      | driving one of the four FCS bytes
  // IFG      | inter-frame gap, tx_en low
  // ABORT    | single error cycle after an underrun
  // DRAIN    | discarding the rest of an aborted frame
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_PREAMBLE = 4'd1;
  localparam logic [3:0] ST_SFD      = 4'd2;
  localparam logic [3:0] ST_DATA     = 4'd3;
  localparam logic [3:0] ST_PAD      = 4'd4;
  localparam logic [3:0] ST_FCS      = 4'd5;
  localparam logic [3:0] ST_IFG      = 4'd6;
  localparam logic [3:0] ST_ABORT    = 4'd7;
  localparam logic [3:0] ST_DRAIN    = 4'd8;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

`ifdef GMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic [3:0]  state;
  logic [7:0]  cnt;
  logic [15:0] byte_cnt;
  logic [31:0] crc;
  logic        pad_needed;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
    logic [31:0] f;
    logic [7:0]  b;
    f = ~c;
    case (idx)
      2'd0:    b = f[7:0];
      2'd1:    b = f[15:8];
      2'd2:    b = f[23:16];
      default: b = f[31:24];
    endcase
    return b;
  endfunction

  // With padding compiled out this is constant low and PAD is never entered.
  assign pad_needed = PAD_EN && (byte_cnt < 16'(MIN_PAYLOAD));
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      byte_cnt    <= 16'd0;
      crc         <= CRC_INIT;
      s_ready     <= 1'b0;
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            state      <= ST_PREAMBLE;
            cnt        <= 8'(PREAMBLE_LEN - 1);
            byte_cnt   <= 16'd0;
            crc        <= CRC_INIT;
            gmii_txd   <= 8'h55;
            gmii_tx_en <= 1'b1;
          end
        end

        ST_PREAMBLE: begin
          if (cnt == 8'd0) begin
            state    <= ST_SFD;
            gmii_txd <= 8'hD5;
            s_ready  <= 1'b1;
          end else begin
            cnt      <= cnt - 8'd1;
            gmii_txd <= 8'h55;
          end
        end

        // s_ready high here means this edge is a handshake edge; low means
        // the last payload byte is on the wire and the tail must be chosen.
        ST_SFD, ST_DATA: begin
          if (s_ready) begin
            if (s_valid) begin
              state    <= ST_DATA;
              gmii_txd <= s_data;
              crc      <= crc_byte(crc, s_data);
              if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
              if (s_last) s_ready <= 1'b0;
            end else begin
              state       <= ST_ABORT;
              gmii_txd    <= 8'h00;
              gmii_tx_er  <= 1'b1;
              frame_abort <= 1'b1;
              s_ready     <= 1'b0;
            end
          end else if (pad_needed) begin
            state    <= ST_PAD;
            gmii_txd <= 8'h00;
            crc      <= crc_byte(crc, 8'h00);
            byte_cnt <= byte_cnt + 16'd1;
          end else begin
            state    <= ST_FCS;
            cnt      <= 8'd0;
            gmii_txd <= fcs_byte(crc, 2'd0);
          end
        end

        ST_PAD: begin
          if (pad_needed) begin
            gmii_txd <= 8'h00;
            crc      <= crc_byte(crc, 8'h00);
            byte_cnt <= byte_cnt + 16'd1;
          end else begin
            state    <= ST_FCS;
            cnt      <= 8'd0;
            gmii_txd <= fcs_byte(crc, 2'd0);
          end
        end

        ST_FCS: begin
          if (cnt == 8'd3) begin
            state      <= ST_IFG;
            cnt        <= 8'(IFG_BYTES - 1);
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
          end else begin
            cnt      <= cnt + 8'd1;
            gmii_txd <= fcs_byte(crc, cnt[1:0] + 2'd1);
            if (cnt == 8'd2) begin
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 16'd1;
            end
          end
        end

        ST_ABORT: begin
          state      <= ST_DRAIN;
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          s_ready    <= 1'b1;
        end

        ST_DRAIN: begin
          if (s_valid && s_last) begin
            state   <= ST_IFG;
            cnt     <= 8'(IFG_BYTES - 1);
            s_ready <= 1'b0;
          end
        end

        ST_IFG: begin
          if (cnt == 8'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          cnt        <= 8'd0;
          s_ready    <= 1'b0;
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Bench for gmii_frame_tx: random payloads against a byte-stream model of the
// expected GMII wire sequence; honours GMII_TX_PAD_EN like the design.
module tb_gmii_frame_tx;

  localparam int PRE = 7;
  localparam int IFG = 12;
  localparam int MIN = 60;
`ifdef GMII_TX_PAD_EN
  localparam bit PAD_MODEL = 1'b1;
`else
  localparam bit PAD_MODEL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;
  logic [15:0] frames_sent;

  gmii_frame_tx dut (
    .clock       (clock),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frames_sent (frames_sent)
  );

  always #4 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int exp_frames = 0;

  // wire monitor, sampled on the falling edge
  int         cyc = 0;
  logic [7:0] tx_q[$];
  int         start_q[$];
  int         done_q[$];
  logic [7:0] done_byte_q[$];
  logic [7:0] er_byte_q[$];
  int         abort_q[$];
  int         last_en_cyc = 0;
  int         busy_fall_cyc = 0;
  time        busy_fall_time = 0;
  logic       prev_en = 1'b0;
  logic       prev_busy = 1'b0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (gmii_tx_en) begin
      tx_q.push_back(gmii_txd);
      if (!prev_en) start_q.push_back(cyc);
      last_en_cyc = cyc;
    end
    if (frame_done) begin
      done_q.push_back(cyc);
      done_byte_q.push_back(gmii_txd);
    end
    if (gmii_tx_er) er_byte_q.push_back(gmii_txd);
    if (frame_abort) abort_q.push_back(cyc);
    if (prev_busy && !busy) begin
      busy_fall_cyc  = cyc;
      busy_fall_time = $time;
    end
    prev_en   = gmii_tx_en;
    prev_busy = busy;
  end

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int         accepted;
  time        last_hs_time;

  task automatic clear_mon();
    tx_q.delete(); start_q.delete(); done_q.delete(); done_byte_q.delete();
    er_byte_q.delete(); abort_q.delete(); exp_q.delete();
    accepted = 0;
  endtask

  // Expected wire bytes of one good frame: preamble, SFD, body (padded if
  // enabled), then the complement of the bit-serial CRC, low byte first.
  function automatic void model_frame(input logic [7:0] pl[$]);
    logic [7:0]  body[$];
    logic [31:0] c;
    logic        fb;
    body = pl;
    if (PAD_MODEL) while (body.size() < MIN) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    c = ~c;
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endfunction

  // Present src_q on the stream; optionally drop s_valid for one cycle
  // right after byte number stall_after has been accepted.
  task automatic send_frame(input int stall_after);
    int  idx;
    int  budget;
    bit  hs;
    bit  stalled;
    idx = 0; budget = 0; stalled = 0;
    s_valid = 1'b1;
    s_data  = src_q[0];
    s_last  = (src_q.size() == 1);
    while (idx < src_q.size()) begin
      @(negedge clock);
      hs = s_valid && s_ready;
      @(posedge clock);
      if (hs) last_hs_time = $time;
      #1;
      if (hs) begin
        idx++; accepted++; budget = 0;
      end else begin
        budget++;
      end
      if (budget > 200) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, src_q.size());
        break;
      end
      if (idx < src_q.size()) begin
        if (hs && !stalled && idx == stall_after) begin
          s_valid = 1'b0;
          stalled = 1;
        end else begin
          s_valid = 1'b1;
          s_data  = src_q[idx];
          s_last  = (idx == src_q.size() - 1);
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    #1;
    if (busy) begin
      vectors++; miscompares++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic random_payload(input int len);
    src_q.delete();
    for (int i = 0; i < len; i++) src_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    logic [29:0] obs;
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    obs = {gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, busy, frame_done, frame_abort, frames_sent};
    vectors++;
    if (obs !== 30'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h required 0", obs);
    end
    @(negedge clock); reset = 1'b0;
    @(negedge clock); s_valid = 1'b1; s_data = 8'hA5;
    repeat (4) @(negedge clock);
    vectors++;
    if (!(busy === 1'b1 && gmii_tx_en === 1'b1 && gmii_txd === 8'h55)) begin
      miscompares++;
      $display("FAIL preamble_running: busy=%b en=%b txd=%h required 1 1 55", busy, gmii_tx_en, gmii_txd);
    end
    #2 reset = 1'b1;
    #1;
    obs = {gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, busy, frame_done, frame_abort, frames_sent};
    vectors++;
    if (obs !== 30'h0) begin
      miscompares++;
      $display("FAIL reset_mid_preamble: got %h required 0", obs);
    end
    s_valid = 1'b0;
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || gmii_tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stays_idle: busy=%b en=%b required 0 0", busy, gmii_tx_en);
    end
  endtask

  task automatic test_known_vector();
    logic [7:0] lit[4];
    lit = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    clear_mon();
    src_q.delete();
    for (int i = 0; i < 9; i++) src_q.push_back(8'(8'h31 + i));
    model_frame(src_q);
    send_frame(-1);
    wait_idle("known");
    exp_frames++;
    vectors++;
    if (tx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL known_len: got %0d bytes required %0d", tx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (tx_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL known_byte[%0d]: got %h required %h", i, tx_q[i], exp_q[i]);
        end
      end
    end
    if (!PAD_MODEL && tx_q.size() == 21) begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (tx_q[17 + i] !== lit[i]) begin
          miscompares++;
          $display("FAIL known_fcs[%0d]: got %h required %h", i, tx_q[17 + i], lit[i]);
        end
      end
    end
    vectors++;
    if (start_q.size() != 1 || last_en_cyc - start_q[0] + 1 != exp_q.size()) begin
      miscompares++;
      $display("FAIL known_en_span: got %0d cycles required %0d", last_en_cyc - start_q[0] + 1, exp_q.size());
    end
    vectors++;
    if (done_q.size() != 1 || done_q[0] != last_en_cyc || done_byte_q[0] !== exp_q[exp_q.size() - 1]) begin
      miscompares++;
      $display("FAIL known_done: got %0d pulses required 1 on last FCS byte %h", done_q.size(), exp_q[exp_q.size() - 1]);
    end
    vectors++;
    if (busy_fall_cyc != last_en_cyc + IFG + 1) begin
      miscompares++;
      $display("FAIL known_ifg: busy fell %0d cycles after last byte, required %0d", busy_fall_cyc - last_en_cyc, IFG + 1);
    end
    vectors++;
    if (frames_sent !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL known_count: got %0d required %0d", frames_sent, exp_frames);
    end
  endtask

  task automatic test_pad();
    clear_mon();
    random_payload(14);
    model_frame(src_q);
    send_frame(-1);
    wait_idle("pad");
    exp_frames++;
    vectors++;
    if (tx_q.size() != (PAD_MODEL ? 72 : 26) || tx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL pad_len: got %0d bytes required %0d", tx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (tx_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL pad_byte[%0d]: got %h required %h", i, tx_q[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (busy_fall_cyc - last_en_cyc != IFG + 1) begin
      miscompares++;
      $display("FAIL pad_ifg: busy fell %0d cycles after last byte, required %0d", busy_fall_cyc - last_en_cyc, IFG + 1);
    end
    vectors++;
    if (frames_sent !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL pad_count: got %0d required %0d", frames_sent, exp_frames);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      clear_mon();
      random_payload($urandom_range(1, 100));
      model_frame(src_q);
      repeat ($urandom_range(0, 5)) @(negedge clock);
      send_frame(-1);
      wait_idle("rand");
      exp_frames++;
      vectors++;
      if (tx_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand%0d_len: got %0d bytes required %0d", f, tx_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          vectors++;
          if (tx_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rand%0d_byte[%0d]: got %h required %h", f, i, tx_q[i], exp_q[i]);
          end
        end
      end
      vectors++;
      if (done_q.size() != 1 || er_byte_q.size() != 0 || frames_sent !== 16'(exp_frames)) begin
        miscompares++;
        $display("FAIL rand%0d_status: done=%0d er=%0d count=%0d required 1 0 %0d", f, done_q.size(), er_byte_q.size(), frames_sent, exp_frames);
      end
    end
  endtask

  task automatic test_underrun();
    clear_mon();
    random_payload(20);
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 5; i++) exp_q.push_back(src_q[i]);
    exp_q.push_back(8'h00);
    send_frame(5);
    wait_idle("underrun");
    vectors++;
    if (tx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL underrun_len: got %0d bytes required %0d", tx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (tx_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL underrun_byte[%0d]: got %h required %h", i, tx_q[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (er_byte_q.size() != 1 || abort_q.size() != 1 || abort_q[0] != last_en_cyc) begin
      miscompares++;
      $display("FAIL underrun_error_cycle: er=%0d abort=%0d required 1 1 on last enabled cycle", er_byte_q.size(), abort_q.size());
    end
    vectors++;
    if (accepted != 20) begin
      miscompares++;
      $display("FAIL underrun_drain: got %0d bytes accepted required 20", accepted);
    end
    vectors++;
    if (busy_fall_time != last_hs_time + 8 * IFG + 4) begin
      miscompares++;
      $display("FAIL underrun_ifg: busy fell at %0t required %0t", busy_fall_time, last_hs_time + 8 * IFG + 4);
    end
    vectors++;
    if (frames_sent !== 16'(exp_frames) || done_q.size() != 0) begin
      miscompares++;
      $display("FAIL underrun_count: got %0d done=%0d required %0d done=0", frames_sent, done_q.size(), exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] second[$];
    clear_mon();
    random_payload($urandom_range(10, 30));
    model_frame(src_q);
    for (int i = 0; i < $urandom_range(5, 20); i++) second.push_back(8'($urandom_range(0, 255)));
    model_frame(second);
    send_frame(-1);
    src_q = second;
    send_frame(-1);
    wait_idle("b2b");
    exp_frames += 2;
    vectors++;
    if (tx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_len: got %0d bytes required %0d", tx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (tx_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b_byte[%0d]: got %h required %h", i, tx_q[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (start_q.size() != 2 || done_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_frames: starts=%0d dones=%0d required 2 2", start_q.size(), done_q.size());
    end else begin
      vectors++;
      if (start_q[1] - done_q[0] != IFG + 2) begin
        miscompares++;
        $display("FAIL b2b_gap: second preamble %0d cycles after last FCS byte, required %0d", start_q[1] - done_q[0], IFG + 2);
      end
    end
    vectors++;
    if (frames_sent !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d required %0d", frames_sent, exp_frames);
    end
  endtask

  task automatic test_wrap();
    @(negedge clock);
    force dut.frames_sent = 16'hFFFF;
    @(negedge clock);
    release dut.frames_sent;
    @(negedge clock);
    vectors++;
    if (frames_sent !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preload: got %h required ffff", frames_sent);
    end
    clear_mon();
    random_payload($urandom_range(1, 70));
    send_frame(-1);
    wait_idle("wrap");
    vectors++;
    if (frames_sent !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_count: got %h required 0000", frames_sent);
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    accepted = 0; last_hs_time = 0;
    test_reset();
    test_known_vector();
    test_pad();
    test_random_frames();
    test_underrun();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gmii_frame_tx.md
Name: gmii_frame_tx

Overview:
- GMII transmit-side framer: the byte-stream-to-GMII producer that drives the gmii_txd / gmii_tx_en / gmii_tx_er inputs of the gig_eth_pcs_pma instance.
- Accepts Ethernet frame payload (destination MAC through end of payload) on a valid/ready byte stream.
- Emits preamble, SFD, payload, optional zero pad, CRC-32 FCS, then inter-frame gap.
- Sits between the microserver packet logic and the PCS/PMA.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD.
- IFG_BYTES, 12, idle cycles (tx_en=0) after each frame or abort.
- MIN_PAYLOAD, 60, minimum bytes before FCS; used only when padding is compiled in.

Ports:
- clock  in  1  GMII transmit clock, 125 MHz.
- reset  in  1  asynchronous, active-high.
- s_data  in  8  payload byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final payload byte; qualified by s_valid.
- s_ready  out  1  framer accepts a byte on this edge when s_valid&s_ready.
- gmii_txd  out  8  registered GMII data.
- gmii_tx_en  out  1  registered GMII enable.
- gmii_tx_er  out  1  registered GMII error.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on the last FCS byte of a good frame.
- frame_abort  out  1  one-cycle pulse on the error cycle of an underrun.
- frames_sent  out  16  count of good frames; wraps 0xFFFF→0x0000.

Behaviour:
- Reset (async): state=IDLE; gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, busy=0, frame_done=0, frame_abort=0, frames_sent=0, CRC=0xFFFFFFFF, counters 0.
- Reset mid-frame: outputs drop to their reset values immediately. No FCS or error cycle is emitted. The upstream source must flush its frame.
- States: IDLE → PREAMBLE → SFD → DATA → PAD → FCS → IFG → IDLE. From DATA on underrun: DATA → ABORT → DRAIN → IFG.
- IDLE: s_ready=0. An edge k with s_valid=1 starts a frame; the byte is not consumed.
- PREAMBLE: cycles k+1..k+PREAMBLE_LEN drive txd=0x55, tx_en=1.
- SFD: next cycle drives txd=0xD5, tx_en=1.
- DATA entry: s_ready rises in the SFD cycle.
- DATA handshake: s_ready=1. A byte accepted at edge e is driven in cycle e+1 with tx_en=1. The CRC updates with that byte and the byte counter increments (saturates at 0xFFFF).
- DATA exit on s_last: when the accepted byte has s_last=1, s_ready drops the next cycle. If pad is enabled and byte count < MIN_PAYLOAD, go to PAD; otherwise go to FCS.
- DATA underrun: s_valid=0 on any DATA edge → ABORT. ABORT lasts one cycle with txd=0x00, tx_en=1, tx_er=1, and frame_abort pulses.
- DRAIN: s_ready=1, bytes are discarded and nothing is transmitted (tx_en=0). Exit to IFG on s_valid&s_last.
- Underrun on the same edge as s_last: none possible. s_last is only seen with s_valid=1.
- PAD: txd=0x00 bytes, which also enter the CRC, until count = MIN_PAYLOAD.
- FCS: 4 cycles drive ~CRC, least-significant byte first. frame_done pulses on the 4th cycle and frames_sent increments on that edge.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise, LSB-first. Computed over payload and pad only, never over preamble or SFD.
- IFG: tx_en=0, txd=0x00 for IFG_BYTES cycles. s_valid is ignored. Return to IDLE. A new frame start is sampled no earlier than the first IDLE edge.
- tx_er is 1 only in ABORT.

Optional Feature:
- GMII_TX_PAD_EN defined: short frames are zero-padded to MIN_PAYLOAD bytes before the FCS, and PAD is reachable.
- GMII_TX_PAD_EN undefined: the PAD state is removed. The FCS immediately follows the last payload byte regardless of length, and MIN_PAYLOAD is unused.

Test Plan:
- Reset mid-PREAMBLE → all outputs return to reset values in the same cycle, frames_sent stays 0, and the next frame starts cleanly from IDLE.
- Pad disabled, payload ASCII "123456789" (9 bytes, no stalls) → txd sequence is 55×7, D5, 31..39, 26 39 F4 CB. tx_en is high for exactly 21 cycles, frame_done pulses on 0xCB, and frames_sent=1.
- Pad enabled, 14-byte payload → 46 bytes of 0x00 follow the payload and the FCS covers all 60 bytes. tx_en is high for 72 cycles, followed by exactly 12 cycles of tx_en=0 before busy falls.
- Underrun: s_valid dropped after the 5th byte of a 20-byte frame → one cycle with tx_en=1, tx_er=1, txd=0x00 and frame_abort=1. The remaining 15 bytes are accepted with tx_en=0, then 12 IFG cycles follow, and frames_sent is unchanged.
- Back-to-back frames with s_valid held high → the second preamble begins exactly 12 cycles after the first frame's last FCS byte plus 1 IDLE cycle. Both FCS values are correct.
- frames_sent preloaded via force to 0xFFFF, then one good frame sent → frames_sent=0x0000.
